// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 scan-code parser with a held-key table and one-cycle press/release events.
// Build option: define PS2KT_REPEAT_EN to report typematic repeats as events.
module ps2_key_tracker #(
  parameter int MAX_KEYS = 4,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ready,
  input  logic [7:0]       data,
  output logic             ev_valid,
  output logic             ev_press,
  output logic             ev_repeat,
  output logic [8:0]       ev_code,
  output logic [8:0]       dout,
  output logic [CNT_W-1:0] held_count,
  output logic             overflow
);

  localparam int IDX_W = (MAX_KEYS > 1) ? $clog2(MAX_KEYS) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXT    = 2'd1,
    S_BRK    = 2'd2,
    S_EXTBRK = 2'd3
  } state_t;

  function automatic logic is_ctrl(input logic [7:0] b);
    case (b)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1: is_ctrl = 1'b1;
      default:                                         is_ctrl = 1'b0;
    endcase
  endfunction

  function automatic logic is_prefix(input logic [7:0] b);
    is_prefix = (b == 8'hE0) || (b == 8'hF0);
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic               make_s;
  logic               brk_s;
  logic               ext_s;
  logic [8:0]         code_s;

  logic [MAX_KEYS-1:0] valid_r;
  logic [8:0]          codes_r [MAX_KEYS];
  logic                hit_s;
  logic [IDX_W-1:0]    hit_idx_s;
  logic                free_s;
  logic [IDX_W-1:0]    free_idx_s;

  logic                ev_valid_r;
  logic                ev_press_r;
  logic [8:0]          ev_code_r;
  logic [8:0]          dout_r;
  logic [CNT_W-1:0]    count_r;
  logic                ovf_r;

  // Byte classification and next parser state
  always_comb begin
    state_nxt_s = state_r;
    make_s      = 1'b0;
    brk_s       = 1'b0;
    ext_s       = 1'b0;
    if (ready) begin
      case (state_r)
        S_IDLE: begin
          if (data == 8'hE0) begin
            state_nxt_s = S_EXT;
          end else if (data == 8'hF0) begin
            state_nxt_s = S_BRK;
          end else if (is_ctrl(data)) begin
            state_nxt_s = S_IDLE;
          end else begin
            make_s = 1'b1;
          end
        end
        S_EXT: begin
          if (data == 8'hF0) begin
            state_nxt_s = S_EXTBRK;
          end else if (data == 8'hE0) begin
            state_nxt_s = S_IDLE;
          end else begin
            make_s      = 1'b1;
            ext_s       = 1'b1;
            state_nxt_s = S_IDLE;
          end
        end
        S_BRK: begin
          state_nxt_s = S_IDLE;
          if (is_prefix(data)) begin
            brk_s = 1'b0;
          end else begin
            brk_s = 1'b1;
          end
        end
        S_EXTBRK: begin
          state_nxt_s = S_IDLE;
          ext_s       = 1'b1;
          if (is_prefix(data)) begin
            brk_s = 1'b0;
          end else begin
            brk_s = 1'b1;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign code_s = {ext_s, data};

  // Table search: descending scan leaves the lowest matching/free index
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = MAX_KEYS - 1; i >= 0; i--) begin
      if (!valid_r[i]) begin
        free_s     = 1'b1;
        free_idx_s = IDX_W'(i);
      end else if (codes_r[i] == code_s) begin
        hit_s     = 1'b1;
        hit_idx_s = IDX_W'(i);
      end else begin
      end
    end
  end

  // Parser state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

`ifdef PS2KT_REPEAT_EN
  logic ev_repeat_r;

  // Repeat flag register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_repeat_r <= 1'b0;
    end else if (make_s && hit_s) begin
      ev_repeat_r <= 1'b1;
    end else if ((make_s && free_s) || (brk_s && hit_s)) begin
      ev_repeat_r <= 1'b0;
    end else begin
      ev_repeat_r <= ev_repeat_r;
    end
  end

  assign ev_repeat = ev_repeat_r;
`else
  assign ev_repeat = 1'b0;
`endif

  // Held-key table, event outputs, dout, count and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r    <= '0;
      for (int i = 0; i < MAX_KEYS; i++) begin
        codes_r[i] <= 9'h000;
      end
      ev_valid_r <= 1'b0;
      ev_press_r <= 1'b0;
      ev_code_r  <= 9'h000;
      dout_r     <= 9'h000;
      count_r    <= '0;
      ovf_r      <= 1'b0;
    end else begin
      ev_valid_r <= 1'b0;
      if (make_s) begin
        if (hit_s) begin
`ifdef PS2KT_REPEAT_EN
          ev_valid_r <= 1'b1;
          ev_press_r <= 1'b1;
          ev_code_r  <= code_s;
`endif
        end else if (free_s) begin
          valid_r[free_idx_s] <= 1'b1;
          codes_r[free_idx_s] <= code_s;
          ev_valid_r          <= 1'b1;
          ev_press_r          <= 1'b1;
          ev_code_r           <= code_s;
          dout_r              <= code_s;
          count_r             <= count_r + CNT_W'(1);
        end else begin
          ovf_r <= 1'b1;
        end
      end else if (brk_s && hit_s) begin
        valid_r[hit_idx_s] <= 1'b0;
        ev_valid_r         <= 1'b1;
        ev_press_r         <= 1'b0;
        ev_code_r          <= code_s;
        count_r            <= count_r - CNT_W'(1);
        if (dout_r == code_s) begin
          dout_r <= 9'h000;
        end else begin
          dout_r <= dout_r;
        end
      end else begin
        ev_valid_r <= 1'b0;
      end
    end
  end

  assign ev_valid   = ev_valid_r;
  assign ev_press   = ev_press_r;
  assign ev_code    = ev_code_r;
  assign dout       = dout_r;
  assign held_count = count_r;
  assign overflow   = ovf_r;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: fixed vector table, corner sequences, random bytes vs a set-based model.
module tb_ps2_key_tracker;
  localparam int MAX_KEYS = 4;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             ready;
  logic [7:0]       data;
  logic             ev_valid, ev_press, ev_repeat;
  logic [8:0]       ev_code, dout;
  logic [CNT_W-1:0] held_count;
  logic             overflow;

  ps2_key_tracker #(.MAX_KEYS(MAX_KEYS), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .ready(ready), .data(data),
    .ev_valid(ev_valid), .ev_press(ev_press), .ev_repeat(ev_repeat),
    .ev_code(ev_code), .dout(dout), .held_count(held_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int evn, rpn;

  // reference model: pending-prefix flags plus the set of held codes
  bit         m_ext, m_brk, m_ovf;
  logic [8:0] m_held[$];
  logic [8:0] m_dout;
  bit         x_valid, x_press, x_repeat;
  logic [8:0] x_code;

  typedef struct {
    logic [7:0] data;
    logic       ev_valid;
    logic       ev_press;
    logic [8:0] ev_code;
    logic [8:0] dout;
    int         count;
  } vec_t;
  vec_t vecs[14];
  logic [7:0] pool[16];

  function automatic bit ctrl_byte(input logic [7:0] b);
    return b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF, 8'hE1};
  endfunction

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_ovf = 1'b0;
    m_held.delete();
    m_dout = 9'h000;
    x_valid = 1'b0; x_press = 1'b0; x_repeat = 1'b0; x_code = 9'h000;
  endtask

  task automatic model_byte(input logic [7:0] b);
    logic [8:0] code;
    int pos;
    x_valid = 1'b0; x_press = 1'b0; x_repeat = 1'b0; x_code = 9'h000;
    if (b == 8'hE0) begin
      if (m_ext || m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
      else m_ext = 1'b1;
      return;
    end
    if (b == 8'hF0) begin
      if (m_brk) begin m_ext = 1'b0; m_brk = 1'b0; end
      else m_brk = 1'b1;
      return;
    end
    code = {m_ext, b};
    pos = -1;
    foreach (m_held[i]) if (m_held[i] == code) pos = i;
    if (m_brk) begin
      if (pos >= 0) begin
        m_held.delete(pos);
        x_valid = 1'b1; x_code = code;
        if (code == m_dout) m_dout = 9'h000;
      end
    end else if (m_ext || !ctrl_byte(b)) begin
      if (pos >= 0) begin
`ifdef PS2KT_REPEAT_EN
        x_valid = 1'b1; x_press = 1'b1; x_repeat = 1'b1; x_code = code;
`endif
      end else if (m_held.size() < MAX_KEYS) begin
        m_held.push_back(code);
        x_valid = 1'b1; x_press = 1'b1; x_code = code;
        m_dout = code;
      end else begin
        m_ovf = 1'b1;
      end
    end
    m_ext = 1'b0; m_brk = 1'b0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, " ev_valid"}, 32'(ev_valid), 32'(x_valid));
    if (x_valid) begin
      chk({tag, " ev_press"}, 32'(ev_press), 32'(x_press));
      chk({tag, " ev_repeat"}, 32'(ev_repeat), 32'(x_repeat));
      chk({tag, " ev_code"}, 32'(ev_code), 32'(x_code));
    end
    chk({tag, " dout"}, 32'(dout), 32'(m_dout));
    chk({tag, " held_count"}, 32'(held_count), m_held.size());
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input bit r, input logic [7:0] d, input string tag);
    ready = r; data = d;
    @(posedge clk); #1;
    ready = 1'b0;
    if (r) model_byte(d);
    else x_valid = 1'b0;
    if (ev_valid === 1'b1) evn++;
    if (ev_valid === 1'b1 && ev_repeat === 1'b1) rpn++;
    check_model(tag);
  endtask

  task automatic send(input logic [7:0] d, input string tag);
    step(1'b1, d, tag);
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_model("reset");
  endtask

  initial begin
    vecs[0]  = '{8'h1C, 1'b1, 1'b1, 9'h01C, 9'h01C, 1};
    vecs[1]  = '{8'hF0, 1'b0, 1'b0, 9'h000, 9'h01C, 1};
    vecs[2]  = '{8'h1C, 1'b1, 1'b0, 9'h01C, 9'h000, 0};
    vecs[3]  = '{8'hE0, 1'b0, 1'b0, 9'h000, 9'h000, 0};
    vecs[4]  = '{8'h75, 1'b1, 1'b1, 9'h175, 9'h175, 1};
    vecs[5]  = '{8'hE0, 1'b0, 1'b0, 9'h000, 9'h175, 1};
    vecs[6]  = '{8'hF0, 1'b0, 1'b0, 9'h000, 9'h175, 1};
    vecs[7]  = '{8'h75, 1'b1, 1'b0, 9'h175, 9'h000, 0};
    vecs[8]  = '{8'h1C, 1'b1, 1'b1, 9'h01C, 9'h01C, 1};
    vecs[9]  = '{8'h1B, 1'b1, 1'b1, 9'h01B, 9'h01B, 2};
    vecs[10] = '{8'hF0, 1'b0, 1'b0, 9'h000, 9'h01B, 2};
    vecs[11] = '{8'h1B, 1'b1, 1'b0, 9'h01B, 9'h000, 1};
    vecs[12] = '{8'hF0, 1'b0, 1'b0, 9'h000, 9'h000, 1};
    vecs[13] = '{8'h1C, 1'b1, 1'b0, 9'h01C, 9'h000, 0};
    pool = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'h14, 8'h6B,
             8'h5A, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'hAA, 8'h00};

    rst = 1'b1; ready = 1'b0; data = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_model("reset state");

    // fixed vectors: single key, extended key, rollover
    for (int i = 0; i < 14; i++) begin
      ready = 1'b1; data = vecs[i].data;
      @(posedge clk); #1;
      ready = 1'b0;
      model_byte(vecs[i].data);
      chk("tbl ev_valid", 32'(ev_valid), 32'(vecs[i].ev_valid));
      if (vecs[i].ev_valid) begin
        chk("tbl ev_press", 32'(ev_press), 32'(vecs[i].ev_press));
        chk("tbl ev_code", 32'(ev_code), 32'(vecs[i].ev_code));
      end
      chk("tbl dout", 32'(dout), 32'(vecs[i].dout));
      chk("tbl held_count", 32'(held_count), vecs[i].count);
    end
    step(1'b0, 8'h00, "pulse end");

    // typematic repeat
    evn = 0; rpn = 0;
    repeat (3) send(8'h1C, "repeat");
`ifdef PS2KT_REPEAT_EN
    chk("repeat events", evn, 3);
    chk("repeat flags", rpn, 2);
`else
    chk("repeat events", evn, 1);
    chk("repeat flags", rpn, 0);
`endif
    chk("repeat held", 32'(held_count), 1);
    send(8'hF0, "repeat clr"); send(8'h1C, "repeat clr");

    // overflow and slot reuse
    evn = 0;
    send(8'h1C, "ovf"); send(8'h1B, "ovf"); send(8'h23, "ovf");
    send(8'h2B, "ovf"); send(8'h34, "ovf");
    chk("ovf press events", evn, 4);
    chk("ovf flag", 32'(overflow), 1);
    chk("ovf held", 32'(held_count), 4);
    send(8'hF0, "ovf rel"); send(8'h1B, "ovf rel");
    send(8'h34, "ovf reinsert");
    chk("ovf reinsert valid", 32'(ev_valid), 1);
    chk("ovf reinsert code", 32'(ev_code), 32'h034);
    send(8'hF0, "ovf clr"); send(8'h1C, "ovf clr");
    send(8'hF0, "ovf clr"); send(8'h23, "ovf clr");
    send(8'hF0, "ovf clr"); send(8'h2B, "ovf clr");
    send(8'hF0, "ovf clr"); send(8'h34, "ovf clr");
    chk("ovf sticky", 32'(overflow), 1);

    // protocol error: F0 F0 aborts, next byte parsed from idle
    send(8'h1C, "err setup");
    evn = 0;
    send(8'hF0, "err"); send(8'hF0, "err");
    chk("err no event", evn, 0);
    send(8'h1C, "err tail");
    chk("err held", 32'(held_count), 1);
    send(8'hF0, "err clr"); send(8'h1C, "err clr");

    // reset mid-sequence discards E0 and clears overflow
    send(8'hE0, "rst mid");
    do_reset();
    send(8'h75, "rst mid make");
    chk("rst mid valid", 32'(ev_valid), 1);
    chk("rst mid code", 32'(ev_code), 32'h075);

    // random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else step($urandom_range(0, 9) < 7, pool[$urandom_range(0, 15)], "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
